// File: rtl/spike_aer_encoder.sv
// Address-event encoder: collects one-cycle neuron fire pulses and emits them one index per handshake, lowest index first.
// Optional macro AER_TIMESTAMP_EN adds a timestep counter and the aer_ts output.
module spike_aer_encoder #(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TS_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_NEURONS-1:0] fire_vec,
    input  logic                   timestep_tick,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ADDR_W-1:0]      aer_addr,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W-1:0]        aer_ts,
`endif
    output logic [7:0]             drop_count,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(NUM_NEURONS + 1);
    localparam int unsigned SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] low_oh, clear_oh, drop_vec;
    logic [ADDR_W-1:0]      low_idx;
    logic                   load;
    logic [CNT_W-1:0]       drop_num;
    logic [SUM_W-1:0]       drop_sum;

    // Isolate the lowest pending bit and encode its index.
    always_comb begin
        low_oh  = pending_q & (~pending_q + NUM_NEURONS'(1));
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (low_oh[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (aer_ready) begin
                    if (pending_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A spike on a bit being loaded this cycle re-arms it; on any other pending bit it is lost.
    always_comb begin
        clear_oh  = load ? low_oh : '0;
        drop_vec  = fire_vec & pending_q & ~clear_oh;
        pending_d = (pending_q & ~clear_oh) | fire_vec;
        drop_num  = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            drop_num = drop_num + CNT_W'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_count) + SUM_W'(drop_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            aer_addr   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (load) begin
                aer_addr <= low_idx;
            end
            if (drop_sum > SUM_W'(255)) begin
                drop_count <= 8'hFF;
            end else begin
                drop_count <= drop_sum[7:0];
            end
            if (drop_vec != '0) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;

    // The stamp is the count before any tick arriving in the load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            aer_ts   <= '0;
        end else begin
            if (timestep_tick) begin
                ts_cnt_q <= ts_cnt_q + TS_W'(1);
            end
            if (load) begin
                aer_ts <= ts_cnt_q;
            end
        end
    end
`else
    logic [TS_W-1:0] unused_ts;
    assign unused_ts = {TS_W{timestep_tick}};
`endif

    assign aer_valid = (state_q == EMIT);
    assign busy      = (pending_q != '0) | aer_valid;

endmodule
